// File: rtl/laccp_avg_accum_axis.sv
// laccp_avg_accum_axis
// Windowed accumulator for unsigned measurement samples.
// At each window close it emits {dividend = sum, divisor = count} on an
// AXIS-like hold register that feeds the fixed-point divider directly.
// Accumulation never stalls. A window that closes while the previous result
// is still held (and not being accepted) is dropped, and the sticky overrun
// flag is raised.
module laccp_avg_accum_axis #(
    parameter int DW = 16,
    parameter int SW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_sample_valid,
    input  logic [SW-1:0] s_sample_data,
    input  logic [DW-1:0] cfg_win_len,
    input  logic          flush,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_dividend,
    output logic [DW-1:0] m_axis_divisor,
    output logic          m_axis_saturated,
    output logic          overrun,
    input  logic          clr_overrun
);

    localparam logic [DW-1:0] ONE   = DW'(1);
    localparam logic [DW-1:0] ZERO  = '0;
    localparam logic [DW-1:0] MAXV  = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Accumulator state
    state_t        state_q, state_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] count_q, count_d;
    logic          sat_q, sat_d;
    logic [DW-1:0] winLen_q, winLen_d;

    // Output hold register
    logic          holdValid_q, holdValid_d;
    logic [DW-1:0] holdDividend_q, holdDividend_d;
    logic [DW-1:0] holdDivisor_q, holdDivisor_d;
    logic          holdSat_q, holdSat_d;
    logic          overrun_q, overrun_d;

    // Values of the window including this cycle's sample, and the close decision
    logic [DW-1:0] sampleExt;
    logic [DW:0]   addResult;
    logic [DW-1:0] windowSum;
    logic [DW-1:0] windowCount;
    logic          windowSat;
    logic          closeWin;
    logic          accept;

    assign sampleExt = DW'(s_sample_data);
    assign addResult = {1'b0, sum_q} + {1'b0, sampleExt};
    assign accept    = holdValid_q & m_axis_tready;

    // Accumulator next state: fold in the sample, then decide whether the window closes
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        count_d     = count_q;
        sat_d       = sat_q;
        winLen_d    = winLen_q;
        windowSum   = sum_q;
        windowCount = count_q;
        windowSat   = sat_q;
        closeWin    = 1'b0;

        case (state_q)
            EMPTY: begin
                if (s_sample_valid) begin
                    winLen_d    = cfg_win_len;
                    windowSum   = sampleExt;
                    windowCount = ONE;
                    windowSat   = 1'b0;
                    closeWin    = (cfg_win_len == ONE) || (ONE == MAXV) || flush;
                end
            end
            ACCUM: begin
                if (s_sample_valid) begin
                    windowSum   = addResult[DW] ? MAXV : addResult[DW-1:0];
                    windowCount = count_q + ONE;
                    windowSat   = sat_q | addResult[DW];
                    closeWin    = ((winLen_q != ZERO) && (windowCount == winLen_q)) ||
                                  (windowCount == MAXV) || flush;
                end else begin
                    closeWin    = flush;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (closeWin) begin
            state_d = EMPTY;
            sum_d   = ZERO;
            count_d = ZERO;
            sat_d   = 1'b0;
        end else if (s_sample_valid) begin
            state_d = ACCUM;
            sum_d   = windowSum;
            count_d = windowCount;
            sat_d   = windowSat;
        end
    end

    // Output hold next state: retire accepted beats, load or drop closed windows
    always_comb begin
        holdValid_d    = holdValid_q;
        holdDividend_d = holdDividend_q;
        holdDivisor_d  = holdDivisor_q;
        holdSat_d      = holdSat_q;
        overrun_d      = overrun_q;

        if (accept) begin
            holdValid_d = 1'b0;
        end

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (closeWin) begin
            if (!holdValid_q || accept) begin
                holdValid_d    = 1'b1;
                holdDividend_d = windowSum;
                holdDivisor_d  = windowCount;
                holdSat_d      = windowSat;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            sum_q    <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            winLen_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            winLen_q <= winLen_d;
        end
    end

    // Output hold and overrun registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdValid_q    <= 1'b0;
            holdDividend_q <= '0;
            holdDivisor_q  <= '0;
            holdSat_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            holdValid_q    <= holdValid_d;
            holdDividend_q <= holdDividend_d;
            holdDivisor_q  <= holdDivisor_d;
            holdSat_q      <= holdSat_d;
            overrun_q      <= overrun_d;
        end
    end

    assign m_axis_tvalid    = holdValid_q;
    assign m_axis_dividend  = holdDividend_q;
    assign m_axis_divisor   = holdDivisor_q;
    assign m_axis_saturated = holdSat_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_laccp_avg_accum_axis.sv
// tb_laccp_avg_accum_axis
// Directed bench with a scoreboard: expected beats are queued when the
// closing stimulus is issued, and a monitor pops and compares every handshake.
module tb_laccp_avg_accum_axis;

    localparam int DW = 16;
    localparam int SW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_sample_valid;
    logic [SW-1:0] s_sample_data;
    logic [DW-1:0] cfg_win_len;
    logic          flush;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_dividend;
    logic [DW-1:0] m_axis_divisor;
    logic          m_axis_saturated;
    logic          overrun;
    logic          clr_overrun;

    typedef struct packed {
        logic [DW-1:0] dividend;
        logic [DW-1:0] divisor;
        logic          sat;
    } beat_t;

    beat_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    laccp_avg_accum_axis #(.DW(DW), .SW(SW)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_sample_valid   (s_sample_valid),
        .s_sample_data    (s_sample_data),
        .cfg_win_len      (cfg_win_len),
        .flush            (flush),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_dividend  (m_axis_dividend),
        .m_axis_divisor   (m_axis_divisor),
        .m_axis_saturated (m_axis_saturated),
        .overrun          (overrun),
        .clr_overrun      (clr_overrun)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Compare one value and keep the running tallies
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of sample/flush, return 1 time unit after the sampling edge
    task automatic applyStimulus(input logic v, input logic [SW-1:0] d, input logic f);
        s_sample_valid = v;
        s_sample_data  = d;
        flush          = f;
        @(posedge clk);
        #1;
        s_sample_valid = 1'b0;
        s_sample_data  = '0;
        flush          = 1'b0;
    endtask

    task automatic pushExp(input int dividend, input int divisor, input logic sat);
        beat_t b;
        b.dividend = DW'(dividend);
        b.divisor  = DW'(divisor);
        b.sat      = sat;
        expQ.push_back(b);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedBeat", 32'(m_axis_dividend), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = expQ.pop_front();
                checkOutput("beatDividend", 32'(m_axis_dividend), 32'(e.dividend));
                checkOutput("beatDivisor", 32'(m_axis_divisor), 32'(e.divisor));
                checkOutput("beatSaturated", 32'(m_axis_saturated), 32'(e.sat));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        s_sample_valid = 1'b0;
        s_sample_data  = '0;
        cfg_win_len    = '0;
        flush          = 1'b0;
        m_axis_tready  = 1'b1;
        clr_overrun    = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetTvalid", 32'(m_axis_tvalid), 0);
        checkOutput("resetDividend", 32'(m_axis_dividend), 0);
        checkOutput("resetDivisor", 32'(m_axis_divisor), 0);
        checkOutput("resetOverrun", 32'(overrun), 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0);

        // Window of 4: 10+20+30+40 = 100, one-cycle latency, one-cycle valid
        $display("[TB] window length 4");
        cfg_win_len = 16'd4;
        pushExp(100, 4, 0);
        applyStimulus(1, 10, 0);
        applyStimulus(1, 20, 0);
        applyStimulus(1, 30, 0);
        checkOutput("win4NotYet", 32'(m_axis_tvalid), 0);
        applyStimulus(1, 40, 0);
        checkOutput("win4Latency", 32'(m_axis_tvalid), 1);
        applyStimulus(0, 0, 0);
        checkOutput("win4OneCycle", 32'(m_axis_tvalid), 0);

        // Unbounded window closed by flush with a sample: 5+7+9+11 = 32
        $display("[TB] unbounded window with flush");
        cfg_win_len = 16'd0;
        pushExp(32, 4, 0);
        applyStimulus(1, 5, 0);
        applyStimulus(1, 7, 0);
        applyStimulus(1, 9, 0);
        applyStimulus(1, 11, 1);
        checkOutput("flushClose", 32'(m_axis_tvalid), 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("flushIdleNoBeat", 32'(m_axis_tvalid), 0);

        // Saturation: 20 x 4095 exceeds 65535
        $display("[TB] saturation");
        cfg_win_len = 16'd20;
        pushExp(65535, 20, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 12'd4095, 0);
        applyStimulus(0, 0, 0);

        // Hold with tready low: first window held, next two dropped
        $display("[TB] hold and overrun");
        cfg_win_len   = 16'd2;
        m_axis_tready = 1'b0;
        pushExp(2, 2, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        checkOutput("holdValid", 32'(m_axis_tvalid), 1);
        checkOutput("noOverrunYet", 32'(overrun), 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        checkOutput("overrunSet", 32'(overrun), 1);
        applyStimulus(1, 1, 0);
        clr_overrun = 1'b1;
        applyStimulus(1, 1, 0);
        clr_overrun = 1'b0;
        checkOutput("overrunSetWins", 32'(overrun), 1);
        checkOutput("holdDividendStable", 32'(m_axis_dividend), 2);
        checkOutput("holdDivisorStable", 32'(m_axis_divisor), 2);
        m_axis_tready = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("holdReleased", 32'(m_axis_tvalid), 0);
        clr_overrun = 1'b1;
        applyStimulus(0, 0, 0);
        clr_overrun = 1'b0;
        checkOutput("overrunCleared", 32'(overrun), 0);

        // Single-sample windows back to back
        $display("[TB] window length 1");
        cfg_win_len = 16'd1;
        pushExp(1, 1, 0);
        pushExp(2, 1, 0);
        pushExp(3, 1, 0);
        applyStimulus(1, 1, 0);
        checkOutput("win1Beat1", 32'(m_axis_tvalid), 1);
        applyStimulus(1, 2, 0);
        checkOutput("win1Beat2", 32'(m_axis_divisor), 1);
        applyStimulus(1, 3, 0);
        checkOutput("win1Beat3", 32'(m_axis_dividend), 3);
        applyStimulus(0, 0, 0);

        // Reset mid-window drops the held result and the partial window
        $display("[TB] reset mid-window");
        m_axis_tready = 1'b0;
        applyStimulus(1, 7, 0);
        checkOutput("preResetHeld", 32'(m_axis_tvalid), 1);
        cfg_win_len = 16'd8;
        applyStimulus(1, 3, 0);
        applyStimulus(1, 3, 0);
        applyStimulus(1, 3, 0);
        rst = 1'b1;
        #1;
        checkOutput("midResetTvalid", 32'(m_axis_tvalid), 0);
        checkOutput("midResetDividend", 32'(m_axis_dividend), 0);
        checkOutput("midResetDivisor", 32'(m_axis_divisor), 0);
        checkOutput("midResetSat", 32'(m_axis_saturated), 0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        m_axis_tready = 1'b1;
        pushExp(16, 8, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, 2, 0);
        checkOutput("postResetNotYet", 32'(m_axis_tvalid), 0);
        applyStimulus(1, 2, 0);
        checkOutput("postResetClose", 32'(m_axis_tvalid), 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);

        checkOutput("scoreboardDrained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/laccp_avg_accum_axis.md
# laccp_avg_accum_axis

Windowed sample accumulator feeding the unsigned fixed-point divider stage. It sums a stream of unsigned measurement samples, such as round-trip or phase-offset deltas, over a configurable window. At window close it presents {dividend = sum, divisor = count} on an AXIS-like output port, which connects directly to the divider's input port. This lets the divider produce a QI.QF mean without any multiplier.

## Interface

Parameters:
- DW, 16: output width of dividend and divisor; also the accumulator and counter width. Must equal the divider's DW.
- SW, 12: input sample width. SW <= DW.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- s_sample_valid, in, 1: sample strobe. There is no ready; a sample is taken every cycle it is high.
- s_sample_data, in, SW: unsigned sample, zero-extended to DW.
- cfg_win_len, in, DW: samples per window. Sampled when a window opens. 0 means unbounded: the window closes only by flush or count saturation.
- flush, in, 1: pulse; closes the current window early.
- m_axis_tvalid, out, 1: result valid.
- m_axis_tready, in, 1: downstream ready; connects to the divider's s_axis_tready.
- m_axis_dividend, out, DW: window sum.
- m_axis_divisor, out, DW: window sample count, always >= 1 when valid.
- m_axis_saturated, out, 1: the window sum clipped at 2^DW-1.
- overrun, out, 1: sticky; a closed window was discarded because the output was still held.
- clr_overrun, in, 1: synchronous clear of overrun.

## Operation

Accumulator state machine:
- EMPTY: sum = 0, count = 0.
  - On a sample, latch win_len_r = cfg_win_len.
  - Set sum = sample, count = 1, sat = 0. Go to ACCUM.
  - If win_len_r == 1, close immediately and stay in EMPTY.
- ACCUM: on each sample, sum += sample and count += 1.
  - Sum is computed in DW+1 bits. On carry, sum = 2^DW-1 and sat = 1.
  - Close when any of these holds, counting the current cycle's sample:
    - count reaches win_len_r (win_len_r != 0);
    - count reaches 2^DW-1;
    - flush is high.
  - After closing, return to EMPTY.

Closing a window:
- If the output hold is empty, or is being accepted in the same cycle (tvalid & tready), load {sum, count, sat} into the hold and set tvalid.
- Otherwise discard the window and set overrun.
- The accumulator returns to EMPTY in either case. Accumulation never stalls and samples are never dropped mid-window.

Boundary rules:
- A flush in EMPTY with no sample in that cycle does nothing; no zero-count output is ever produced.
- A flush in EMPTY with a sample in that cycle closes a 1-sample window.
- A flush and a sample in the same cycle: the sample is included in the closing window.
- cfg_win_len changes take effect only at the next window open.
- clr_overrun and an overrun event in the same cycle: overrun stays 1 (set wins).
- Output hold: tvalid stays high and the data stays stable until tvalid & tready.

## Timing

- Reset values: m_axis_tvalid = 0, dividend = 0, divisor = 0, saturated = 0, overrun = 0. Accumulator goes to EMPTY with win_len_r = 0.
- Sample at edge t updates sum and count at edge t+1.
- Closing sample or flush at cycle t: tvalid = 1 and data valid from t+1. Latency is 1 cycle.
- A sample arriving at t+1 after a close at t opens a new window. This gives back-to-back windows with no dead cycles.
- Output accepted at edge e: tvalid is low after e, unless a new close occurs in the same cycle, in which case tvalid stays 1 with the new data.
- Reset asserted mid-window: the partial window and any held result are lost, and no output is produced.
- With the divider downstream: the divider's ready is low for QI+QF+2 cycles or more per result. Windows shorter than that interval overrun by design.

## Test plan

- win_len = 4, samples 10, 20, 30, 40 on consecutive cycles, tready = 1 -> one beat {dividend = 100, divisor = 4, sat = 0}, tvalid high for one cycle only, one cycle after the sample 40.
- win_len = 0, samples 5, 7, 9, then flush together with sample 11 -> {32, 4}. A further flush alone -> no output.
- DW = 16, SW = 12, win_len = 20, every sample 4095 -> {65535, 20, saturated = 1}.
- win_len = 2, tready held at 0, 6 samples of 1 -> first {2, 2} held stable, the next two windows are discarded, overrun = 1. Raising tready -> {2, 2} accepted. clr_overrun -> overrun = 0.
- win_len = 1, continuous samples 1, 2, 3, tready = 1 -> beats {1,1}, {2,1}, {3,1} on consecutive cycles.
- rst asserted mid-window after 3 samples with win_len = 8 -> all outputs 0 immediately. The next 8 samples produce a single clean window.
